// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: command and state encodings,
// plus a decode helper for the shift-class commands.
// Optional feature macro: SHIFTER_ROTATE_EN (enables rotate-right, cmd 101).
package shifter_pkg;

    typedef enum logic [2:0] {
        SH_NOP  = 3'b000,
        SH_LOAD = 3'b001,
        SH_SHL  = 3'b010,
        SH_SHR  = 3'b011,
        SH_SRA  = 3'b100,
        SH_ROR  = 3'b101
    } shift_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    // True for encodings that start a multicycle shift; rotate only counts
    // when the rotate feature is built in, otherwise 101 decodes as nop.
    function automatic logic is_shift_cmd(input logic [2:0] c);
        logic r;
        case (c)
            SH_SHL, SH_SHR, SH_SRA: r = 1'b1;
`ifdef SHIFTER_ROTATE_EN
            SH_ROR:                 r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit step of the iterative shifter: (op, d) -> d'.
// The rotate leg exists only when SHIFTER_ROTATE_EN is defined.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  shift_cmd_e         op_i,
    input  logic [WIDTH-1:0]   d_i,
    output logic [WIDTH-1:0]   q_o
);

    // Select the single-bit shift for the latched operation.
    always_comb begin
        q_o = d_i;
        case (op_i)
            SH_SHL:  q_o = {d_i[WIDTH-2:0], 1'b0};
            SH_SHR:  q_o = {1'b0, d_i[WIDTH-1:1]};
            SH_SRA:  q_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
`ifdef SHIFTER_ROTATE_EN
            SH_ROR:  q_o = {d_i[0], d_i[WIDTH-1:1]};
`endif
            default: q_o = d_i;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multicycle shifter feeding the ALUOut shifter leg. Loads an operand, then
// shifts one bit per cycle by the captured amount, with busy/done handshakes.
// Optional feature macro: SHIFTER_ROTATE_EN (cmd 101 = rotate right).
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               cmd_ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    shift_state_e        state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    shift_cmd_e          op_q, op_d;
    logic [WIDTH-1:0]    step_s;
    logic                accept_s;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i (op_q),
        .d_i  (data_q),
        .q_o  (step_s)
    );

    // Commands are only taken outside SHIFT; anything offered during a shift is dropped.
    assign accept_s  = cmd_valid && (state_q != ST_SHIFT);

    // Handshake outputs decode directly from the state register.
    assign cmd_ready = (state_q != ST_SHIFT);
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign data_out  = data_q;

    // Next-state logic: step while shifting, otherwise evaluate any accepted command.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_SHIFT: begin
                data_d = step_s;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_IDLE, ST_DONE: begin
                // DONE lasts one cycle unless a new command replaces it.
                state_d = ST_IDLE;
                if (accept_s) begin
                    if (cmd == SH_LOAD) begin
                        data_d  = data_in;
                        state_d = ST_DONE;
                    end else if (is_shift_cmd(cmd)) begin
                        if (shamt == SHAMT_W'(0)) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = shamt;
                            op_d    = shift_cmd_e'(cmd);
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        // nop and undefined encodings leave everything alone
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched op and data register; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= {WIDTH{1'b0}};
            cnt_q   <= {SHAMT_W{1'b0}};
            op_q    <= SH_NOP;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed self-checking bench for iterative_shifter. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active rising edge.
// Optional feature macro: SHIFTER_ROTATE_EN selects the rotate expectations.
module tb_iterative_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;
    int done_cnt;
    logic [31:0] done_data;
    logic        got_done;

    always #5 clk = ~clk;

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .data_in   (data_in),
        .shamt     (shamt),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle, ending on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer a command for exactly one rising edge, then withdraw it.
    task automatic do_cmd(input logic [2:0] c, input logic [31:0] d, input logic [4:0] s);
        cmd_valid = 1'b1;
        cmd       = c;
        data_in   = d;
        shamt     = s;
        step();
        cmd_valid = 1'b0;
        cmd       = 3'b000;
    endtask

    // Run until done (bounded), counting busy cycles and done pulses, capturing the result.
    task automatic run_to_done(input int budget);
        busy_cnt = 0;
        done_cnt = 0;
        got_done = 1'b0;
        done_data = 32'h0;
        for (int i = 0; i < budget; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (!got_done) done_data = data_out;
                got_done = 1'b1;
            end
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 3'b000;
        data_in   = 32'h0;
        shamt     = 5'd0;
        @(negedge clk);
        step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_data",  data_out, 32'h0);
        check("rst_busy",  {31'b0, busy}, 32'h0);
        check("rst_done",  {31'b0, done}, 32'h0);
        check("rst_ready", {31'b0, cmd_ready}, 32'h1);

        // 1: load then back-to-back shl 1
        do_cmd(3'b001, 32'h8000_0001, 5'd0);
        check("t1_load_done", {31'b0, done}, 32'h1);
        check("t1_load_data", data_out, 32'h8000_0001);
        do_cmd(3'b010, 32'h0, 5'd1);
        check("t1_busy",   {31'b0, busy}, 32'h1);
        check("t1_ready0", {31'b0, cmd_ready}, 32'h0);
        check("t1_nodone", {31'b0, done}, 32'h0);
        step();
        check("t1_done", {31'b0, done}, 32'h1);
        check("t1_data", data_out, 32'h0000_0002);
        check("t1_busy_end", {31'b0, busy}, 32'h0);
        step();
        check("t1_done_pulse", {31'b0, done}, 32'h0);

        // 2: sra 4 on a negative operand
        do_cmd(3'b001, 32'h8000_0000, 5'd0);
        do_cmd(3'b100, 32'h0, 5'd4);
        run_to_done(10);
        check("t2_busy_cycles", busy_cnt, 32'd4);
        check("t2_done_pulses", done_cnt, 32'd1);
        check("t2_data", done_data, 32'hF800_0000);

        // 3: shr 31, then zero-amount shifts
        do_cmd(3'b001, 32'hFFFF_FFFF, 5'd0);
        do_cmd(3'b011, 32'h0, 5'd31);
        run_to_done(40);
        check("t3_busy_cycles", busy_cnt, 32'd31);
        check("t3_done_pulses", done_cnt, 32'd1);
        check("t3_data", done_data, 32'h0000_0001);
        do_cmd(3'b011, 32'h0, 5'd0);
        check("t3_z_done", {31'b0, done}, 32'h1);
        check("t3_z_busy", {31'b0, busy}, 32'h0);
        check("t3_z_data", data_out, 32'h0000_0001);
        do_cmd(3'b010, 32'h0, 5'd0);
        check("t3_z2_done", {31'b0, done}, 32'h1);
        check("t3_z2_data", data_out, 32'h0000_0001);

        // 4: load offered mid-shift is ignored
        do_cmd(3'b001, 32'hFFFF_FFFF, 5'd0);
        do_cmd(3'b010, 32'h0, 5'd8);
        step();
        cmd_valid = 1'b1;
        cmd       = 3'b001;
        data_in   = 32'h0000_1234;
        check("t4_ready0", {31'b0, cmd_ready}, 32'h0);
        step();
        cmd_valid = 1'b0;
        cmd       = 3'b000;
        run_to_done(12);
        check("t4_done_pulses", done_cnt, 32'd1);
        check("t4_data", done_data, 32'hFFFF_FF00);

        // 5: reset mid-shift
        do_cmd(3'b001, 32'h0000_00FF, 5'd0);
        do_cmd(3'b010, 32'h0, 5'd8);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_data",  data_out, 32'h0);
        check("t5_busy",  {31'b0, busy}, 32'h0);
        check("t5_done",  {31'b0, done}, 32'h0);
        check("t5_ready", {31'b0, cmd_ready}, 32'h1);
        run_to_done(12);
        check("t5_no_done", done_cnt, 32'd0);
        check("t5_data_hold", data_out, 32'h0);

        // 6: rotate (feature-dependent) and always-nop encodings
        do_cmd(3'b001, 32'h0000_000F, 5'd0);
        step();
        do_cmd(3'b101, 32'h0, 5'd4);
`ifdef SHIFTER_ROTATE_EN
        run_to_done(10);
        check("t6_ror_busy", busy_cnt, 32'd4);
        check("t6_ror_done", done_cnt, 32'd1);
        check("t6_ror_data", done_data, 32'hF000_0000);
        do_cmd(3'b001, 32'h0000_000F, 5'd0);
        step();
`else
        check("t6_ror_nop_done", {31'b0, done}, 32'h0);
        check("t6_ror_nop_busy", {31'b0, busy}, 32'h0);
        run_to_done(8);
        check("t6_ror_nop_pulses", done_cnt, 32'd0);
        check("t6_ror_nop_data", data_out, 32'h0000_000F);
`endif
        do_cmd(3'b110, 32'hDEAD_BEEF, 5'd3);
        check("t6_110_done", {31'b0, done}, 32'h0);
        do_cmd(3'b111, 32'hDEAD_BEEF, 5'd3);
        check("t6_111_done", {31'b0, done}, 32'h0);
        do_cmd(3'b000, 32'hDEAD_BEEF, 5'd3);
        check("t6_000_done", {31'b0, done}, 32'h0);
        check("t6_nop_data", data_out, 32'h0000_000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
